icache_axi_rd_bridge: RTL and testbench
=======================================

Name: icache_axi_rd_bridge

Overview:
Responder end of the instruction-cache miss interface. Accepts one cached line-refill or uncached single-word read from the I-cache, performs the matching AXI4 read transaction, and returns the data as one 128-bit ret_data pulse. Sits between the I-cache and the AXI crossbar/arbiter. Read-only; one outstanding transaction at a time.

Parameters:
LINE_WORD_NUM, 4, 32-bit words per cache line; ret_data width is 32*LINE_WORD_NUM.
ID_WIDTH, 4, AXI ID width.
ARID_VAL, 0, constant ID driven on arid.

Ports:
clk_g  in  1  clock
rst  in  1  synchronous, active-high reset
rd_req  in  1  I-cache read request, held until accepted
rd_uncache  in  1  1 = single-word uncached read
rd_addr  in  32  request address
rd_rdy  out  1  request accepted this cycle when rd_req=1
ret_valid  out  1  one-cycle pulse, ret_data valid
ret_data  out  32*LINE_WORD_NUM  returned line/word
ret_err  out  1  qualifies ret_valid; any beat had rresp != OKAY
arid  out  ID_WIDTH  AXI AR ID
araddr  out  32  AXI AR address
arlen  out  8  AXI AR burst length
arsize  out  3  AXI AR size
arburst  out  2  AXI AR burst type
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rid  in  ID_WIDTH  AXI R ID (ignored)
rdata  in  32  AXI R data
rresp  in  2  AXI R response
rlast  in  1  AXI R last
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready

Behaviour:
- Clock and reset: one clock, clk_g; reset is synchronous and active-high, port rst.
- Reset: state=IDLE, arvalid=0, rready=0, ret_valid=0, ret_err=0, ret_data=0, beat counter=0. rst mid-transaction aborts immediately with no ret_valid. It is a global-reset-only event; the AXI slave is reset together with this block.
- FSM states: IDLE, ADDR, DATA, RET.
- IDLE:
  - rd_rdy=1 (combinational, state-based only).
  - When rd_req=1, latch rd_uncache and the address, clear the line buffer, counter and error flag, then go to ADDR.
  - Cached address is forced line-aligned (low log2(4*LINE_WORD_NUM) bits zeroed). Uncached address is word-aligned (low 2 bits zeroed).
- ADDR:
  - arvalid=1, registered, and stable until arready.
  - Cached: arlen=LINE_WORD_NUM-1, arsize=3'b010, arburst=INCR (2'b01).
  - Uncached: arlen=0, arsize=3'b010, arburst=INCR.
  - On arready, go to DATA.
  - arid=ARID_VAL at all times. AR fields hold their last value outside ADDR.
- DATA: rready=1.
  - Cached: each beat with rvalid writes rdata to word[cnt], bits [32*cnt+31:32*cnt], then cnt++. cnt saturates at LINE_WORD_NUM-1; extra beats overwrite the top word.
  - Uncached: the single beat goes to ret_data[127:96]; all other bits are 0.
  - ret_err is set sticky if any beat has rresp[1]=1.
  - A beat with rlast=1 is accepted, then the FSM goes to RET. Completion is driven by rlast only; a short burst leaves the unwritten words 0.
- RET: ret_valid=1 for exactly one cycle, ret_data/ret_err valid, then IDLE. ret_data holds its value until the next accept. rd_rdy=0 in ADDR, DATA and RET, so a request arriving then waits.
- Latency: accept at cycle T; arvalid rises at T+1. With arready at T+1 and back-to-back beats at T+2..T+5, ret_valid occurs at T+6 (cached) or T+3 (uncached).
- rvalid outside DATA is ignored (rready=0).

Decomposition:
- Shared package (cpu.svh / axi package): AXI burst/size/resp constants (BURST_INCR, SIZE_4B, RESP_OKAY, RESP_SLVERR, RESP_DECERR) and the bridge state_t enum.
- No sub-module; line assembly is an indexed register write inside the block.

Test Plan:
- Cached refill: rd_req=1, rd_uncache=0, rd_addr=0x1FC0_0014, arready=1 immediately, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 (rlast on the 4th). Expect:
  - rd_rdy=1 at T; araddr=0x1FC0_0010, arlen=3 at T+1.
  - ret_valid at T+6 with ret_data=0x44444444_33333333_22222222_11111111, ret_err=0.
- Uncached read: rd_uncache=1, rd_addr=0xBFC0_0006, rdata=0xDEADBEEF with rlast. Expect araddr=0xBFC0_0004, arlen=0, ret_data=0xDEADBEEF_00000000_00000000_00000000 at T+3.
- Backpressure: arready low for 3 cycles, rvalid gaps between beats. Expect:
  - arvalid and araddr held stable until arready.
  - Words land in order; exactly one ret_valid.
- Error: the 2nd beat has rresp=2'b10. Expect ret_err=1 with ret_valid, all 4 words captured; the next clean request gives ret_err=0.
- Back-to-back: rd_req held high through RET. Expect:
  - rd_rdy=0 during ADDR, DATA and RET.
  - Second accept in the IDLE cycle after ret_valid; no overlap of transactions.
- Reset mid-burst: assert rst after 2 beats. Expect next cycle IDLE, arvalid=0, rready=0, ret_valid never pulses; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared AXI read constants and bridge FSM encoding for the I-cache miss bridge.
package icache_axi_rd_bridge_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RET
    } state_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// Turns one I-cache line refill or uncached word read into a single AXI4 read
// burst and returns the result as one wide ret_data pulse.
module icache_axi_rd_bridge
    import icache_axi_rd_bridge_pkg::*;
#(
    parameter int LINE_WORD_NUM = 4,
    parameter int ID_WIDTH      = 4,
    parameter int ARID_VAL      = 0
) (
    input  logic                        clk_g,
    input  logic                        rst,
    input  logic                        rd_req,
    input  logic                        rd_uncache,
    input  logic [31:0]                 rd_addr,
    output logic                        rd_rdy,
    output logic                        ret_valid,
    output logic [32*LINE_WORD_NUM-1:0] ret_data,
    output logic                        ret_err,
    output logic [ID_WIDTH-1:0]         arid,
    output logic [31:0]                 araddr,
    output logic [7:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [ID_WIDTH-1:0]         rid,
    input  logic [31:0]                 rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready
);

    localparam int OFF_W = $clog2(4 * LINE_WORD_NUM);
    localparam int CNT_W = (LINE_WORD_NUM > 1) ? $clog2(LINE_WORD_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORD_NUM - 1);

    state_t state_q, state_d;

    logic                               uncache_q;
    logic                               arvalid_q;
    logic [31:0]                        araddr_q;
    logic [7:0]                         arlen_q;
    logic [2:0]                         arsize_q;
    logic [1:0]                         arburst_q;
    logic [CNT_W-1:0]                   cnt_q;
    logic [LINE_WORD_NUM-1:0][31:0]     line_q;
    logic                               err_q;

    logic accept;
    logic beat;
    logic unused_ok;

    always_ff @(posedge clk_g) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion follows rlast alone, so short or over-long bursts still terminate.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (rd_req)           state_d = ST_ADDR;
            ST_ADDR: if (arready)          state_d = ST_DATA;
            ST_DATA: if (rvalid && rlast)  state_d = ST_RET;
            ST_RET:                        state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_rdy    = (state_q == ST_IDLE);
        rready    = (state_q == ST_DATA);
        ret_valid = (state_q == ST_RET);
    end

    assign accept = rd_rdy && rd_req;
    assign beat   = rready && rvalid;

    always_ff @(posedge clk_g) begin
        if (rst) begin
            uncache_q <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            cnt_q     <= '0;
            line_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                uncache_q <= rd_uncache;
                arvalid_q <= 1'b1;
                arsize_q  <= SIZE_4B;
                arburst_q <= BURST_INCR;
                cnt_q     <= '0;
                line_q    <= '0;
                err_q     <= 1'b0;
                if (rd_uncache) begin
                    araddr_q <= {rd_addr[31:2], 2'b00};
                    arlen_q  <= '0;
                end else begin
                    araddr_q <= {rd_addr[31:OFF_W], OFF_W'(0)};
                    arlen_q  <= 8'(LINE_WORD_NUM - 1);
                end
            end else if (arvalid_q && arready) begin
                arvalid_q <= 1'b0;
            end

            // Uncached word lands in the top slot; cached beats past the line end overwrite it.
            if (beat) begin
                if (uncache_q) begin
                    line_q[LAST_IDX] <= rdata;
                end else begin
                    line_q[cnt_q] <= rdata;
                    if (cnt_q != LAST_IDX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                if (resp_is_err(rresp)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign arid     = ID_WIDTH'(ARID_VAL);
    assign araddr   = araddr_q;
    assign arlen    = arlen_q;
    assign arsize   = arsize_q;
    assign arburst  = arburst_q;
    assign arvalid  = arvalid_q;
    assign ret_data = line_q;
    assign ret_err  = err_q;

    assign unused_ok = ^{rid, rd_addr[1:0]};

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Scoreboard bench for icache_axi_rd_bridge: a driver issues requests and queues
// expected AR/return results, a behavioural AXI slave replays planned beats.
module tb_icache_axi_rd_bridge;
    import icache_axi_rd_bridge_pkg::*;

    localparam int LWN = 4;
    localparam int LW  = 32 * LWN;

    logic          clk_g = 1'b0;
    logic          rst;
    logic          rd_req;
    logic          rd_uncache;
    logic [31:0]   rd_addr;
    logic          rd_rdy;
    logic          ret_valid;
    logic [LW-1:0] ret_data;
    logic          ret_err;
    logic [3:0]    arid;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [3:0]    rid;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    icache_axi_rd_bridge #(.LINE_WORD_NUM(LWN), .ID_WIDTH(4), .ARID_VAL(0)) dut (
        .clk_g(clk_g), .rst(rst), .rd_req(rd_req), .rd_uncache(rd_uncache), .rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_data(ret_data), .ret_err(ret_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk_g = ~clk_g;

    int cyc = 0;
    always @(posedge clk_g) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]      addr;
        logic             unc;
        logic [3:0]       ar_delay;
        logic [3:0]       nbeats;
        logic [7:0][31:0] data;
        logic [7:0][1:0]  resp;
        logic [7:0][3:0]  gap;
    } plan_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } exp_ar_t;

    typedef struct packed {
        logic [LW-1:0] data;
        logic          err;
        logic [7:0]    lat;
    } exp_ret_t;

    plan_t    plan_q[$];
    exp_ar_t  ar_q[$];
    exp_ret_t ret_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int acc_cyc = 0;
    int drv_acc_cyc = 0;
    int last_ret_cyc = 0;
    int beats_seen = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    exp_ar_t     ea;
    exp_ret_t    er;

    function automatic void check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    // Reference model: what the bridge must request and return for a planned transaction.
    function automatic exp_ar_t model_ar(input plan_t p);
        exp_ar_t e;
        e.addr = p.unc ? (p.addr & 32'hFFFF_FFFC) : (p.addr & ~32'(4 * LWN - 1));
        e.len  = p.unc ? 8'd0 : 8'(LWN - 1);
        return e;
    endfunction

    function automatic exp_ret_t model_ret(input plan_t p);
        exp_ret_t e;
        logic [LW-1:0] line;
        bit fast;
        line = '0;
        e.err = 1'b0;
        fast = (p.ar_delay == 0);
        for (int i = 0; i < int'(p.nbeats); i++) begin
            int w;
            w = p.unc ? LWN - 1 : ((i < LWN) ? i : LWN - 1);
            line[32*w +: 32] = p.data[i];
            if (p.resp[i] != RESP_OKAY) e.err = 1'b1;
            if (p.gap[i] != 0) fast = 0;
        end
        e.data = line;
        e.lat  = fast ? 8'(2 + int'(p.nbeats)) : 8'd0;
        return e;
    endfunction

    function automatic plan_t rand_plan();
        plan_t p;
        bit fast;
        int r;
        p = '0;
        p.addr = $urandom;
        p.unc = ($urandom_range(0, 3) == 0);
        p.ar_delay = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 3));
        if (p.unc) p.nbeats = 4'd1;
        else begin
            r = $urandom_range(0, 5);
            p.nbeats = (r == 0) ? 4'($urandom_range(2, 3)) : (r == 1) ? 4'd5 : 4'd4;
        end
        fast = ($urandom_range(0, 1) == 1);
        for (int i = 0; i < 8; i++) begin
            p.data[i] = $urandom;
            r = $urandom_range(0, 7);
            p.resp[i] = (r == 0) ? RESP_SLVERR : (r == 1) ? RESP_DECERR : RESP_OKAY;
            p.gap[i] = fast ? 4'd0 : 4'($urandom_range(0, 2));
        end
        return p;
    endfunction

    function automatic plan_t fixed_plan(input logic [31:0] addr, input logic unc, input logic [3:0] nb);
        plan_t p;
        p = '0;
        p.addr = addr;
        p.unc = unc;
        p.nbeats = nb;
        for (int i = 0; i < 8; i++) p.data[i] = 32'h1111_1111 * (i + 1);
        return p;
    endfunction

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    task automatic issue(input plan_t p, input bit hold);
        int waited;
        waited = 0;
        plan_q.push_back(p);
        ar_q.push_back(model_ar(p));
        ret_q.push_back(model_ret(p));
        rd_req = 1'b1;
        rd_uncache = p.unc;
        rd_addr = p.addr;
        forever begin
            @(negedge clk_g);
            if (rd_rdy) break;
            waited++;
            if (waited > 300) begin
                fail_now("accept_timeout");
                finish_run();
            end
        end
        drv_acc_cyc = cyc;
        @(posedge clk_g); #1;
        if (!hold) rd_req = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (ret_q.size() > 0) begin
            @(posedge clk_g); #1;
            n++;
            if (n > 600) begin
                fail_now("ret_timeout");
                ret_q.delete();
                ar_q.delete();
                plan_q.delete();
            end
        end
        repeat (2) @(posedge clk_g);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents an AR handshake or a return.
    initial begin : monitor
        forever begin
            @(negedge clk_g);
            if (rst) begin
                pend = 1'b0;
                continue;
            end
            if (rd_req && rd_rdy) acc_cyc = cyc;
            if (arvalid || rready || ret_valid) check("rd_rdy_busy", LW'(rd_rdy), LW'(0));
            if (pend) begin
                check("arvalid_hold", LW'(arvalid), LW'(1));
                check("araddr_hold", LW'(araddr), LW'(pend_addr));
            end
            pend = arvalid && !arready;
            pend_addr = araddr;
            if (arvalid && arready) begin
                if (ar_q.size() == 0) fail_now("unexpected_ar");
                else begin
                    ea = ar_q.pop_front();
                    check("araddr", LW'(araddr), LW'(ea.addr));
                    check("arlen", LW'(arlen), LW'(ea.len));
                    check("arsize", LW'(arsize), LW'(SIZE_4B));
                    check("arburst", LW'(arburst), LW'(BURST_INCR));
                    check("arid", LW'(arid), LW'(0));
                end
            end
            if (rvalid && rready) beats_seen++;
            if (ret_valid) begin
                if (ret_q.size() == 0) fail_now("unexpected_ret_valid");
                else begin
                    er = ret_q.pop_front();
                    check("ret_data", ret_data, er.data);
                    check("ret_err", LW'(ret_err), LW'(er.err));
                    if (er.lat != 0) check("ret_latency", LW'(cyc - acc_cyc), LW'(er.lat));
                end
                last_ret_cyc = cyc;
            end
        end
    end

    // Behavioural AXI slave replaying the planned beats with the planned stalls.
    initial begin : slave
        plan_t cur;
        int phase, idx, gapc, waited;
        bit hs_ar, hs_r, arv, rs, rl;
        cur = '0;
        phase = 0; idx = 0; gapc = 0; waited = 0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
        forever begin
            @(negedge clk_g);
            hs_ar = arvalid && arready;
            hs_r = rvalid && rready;
            arv = arvalid;
            rs = rst;
            rl = rlast;
            @(posedge clk_g); #1;
            if (rs) begin
                phase = 0; idx = 0; gapc = 0; waited = 0;
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
                continue;
            end
            if (phase == 0) begin
                if (hs_ar && plan_q.size() > 0) begin
                    cur = plan_q.pop_front();
                    phase = 1; idx = 0; gapc = 0; waited = 0;
                    arready = 1'b0;
                end else begin
                    if (arv) waited++;
                    arready = (plan_q.size() > 0) && (waited >= int'(plan_q[0].ar_delay));
                end
            end else if (hs_r) begin
                if (rl) begin
                    phase = 0; rvalid = 1'b0; rlast = 1'b0;
                end else begin
                    idx++; gapc = 0;
                end
            end
            if (phase == 1) begin
                if (gapc < int'(cur.gap[idx])) begin
                    rvalid = 1'b0;
                    gapc++;
                end else begin
                    rvalid = 1'b1;
                    rdata = cur.data[idx];
                    rresp = cur.resp[idx];
                    rlast = (idx == int'(cur.nbeats) - 1);
                    rid = 4'($urandom);
                end
            end
        end
    end

    initial begin : driver
        plan_t p, p2;
        int b0, n;
        rst = 1'b1; rd_req = 1'b0; rd_uncache = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk_g);
        #1 rst = 1'b0;
        @(negedge clk_g);
        check("rst_rd_rdy", LW'(rd_rdy), LW'(1));
        check("rst_arvalid", LW'(arvalid), LW'(0));
        check("rst_rready", LW'(rready), LW'(0));
        check("rst_ret_valid", LW'(ret_valid), LW'(0));
        check("rst_ret_err", LW'(ret_err), LW'(0));
        check("rst_ret_data", ret_data, LW'(0));
        @(posedge clk_g); #1;

        // Cached refill, no stalls.
        p = fixed_plan(32'h1FC0_0014, 1'b0, 4'd4);
        issue(p, 0);
        wait_done();

        // Uncached word.
        p = fixed_plan(32'hBFC0_0006, 1'b1, 4'd1);
        p.data[0] = 32'hDEAD_BEEF;
        issue(p, 0);
        wait_done();

        // AR backpressure and gaps between beats.
        p = fixed_plan(32'h0000_1238, 1'b0, 4'd4);
        p.ar_delay = 4'd3;
        p.gap[1] = 4'd1; p.gap[2] = 4'd2; p.gap[3] = 4'd3;
        issue(p, 0);
        wait_done();

        // Error on the second beat, then a clean request.
        p = fixed_plan(32'h8000_0040, 1'b0, 4'd4);
        p.resp[1] = RESP_SLVERR;
        issue(p, 0);
        wait_done();
        p = fixed_plan(32'h8000_0080, 1'b0, 4'd4);
        issue(p, 0);
        wait_done();

        // Short burst and over-long burst.
        p = fixed_plan(32'h0000_2000, 1'b0, 4'd2);
        issue(p, 0);
        wait_done();
        p = fixed_plan(32'h0000_3000, 1'b0, 4'd6);
        p.resp[5] = RESP_DECERR;
        issue(p, 0);
        wait_done();

        // Back-to-back with rd_req held through RET.
        p = fixed_plan(32'h0000_4004, 1'b0, 4'd4);
        p2 = fixed_plan(32'h0000_500C, 1'b1, 4'd1);
        issue(p, 1);
        issue(p2, 0);
        check("b2b_accept_gap", LW'(drv_acc_cyc - last_ret_cyc), LW'(1));
        wait_done();

        // Reset after two accepted beats.
        p = fixed_plan(32'h0000_6000, 1'b0, 4'd4);
        b0 = beats_seen;
        issue(p, 0);
        n = 0;
        while (beats_seen - b0 < 2) begin
            @(posedge clk_g); #1;
            n++;
            if (n > 100) begin
                fail_now("beat_timeout");
                finish_run();
            end
        end
        rst = 1'b1;
        plan_q.delete();
        ar_q.delete();
        ret_q.delete();
        @(posedge clk_g); #1;
        rst = 1'b0;
        @(negedge clk_g);
        check("midrst_arvalid", LW'(arvalid), LW'(0));
        check("midrst_rready", LW'(rready), LW'(0));
        check("midrst_rd_rdy", LW'(rd_rdy), LW'(1));
        repeat (6) @(posedge clk_g);
        #1;
        p = fixed_plan(32'h0000_7010, 1'b0, 4'd4);
        issue(p, 0);
        wait_done();

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            p = rand_plan();
            issue(p, ($urandom_range(0, 3) == 0) && (i < 39));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 3)) @(posedge clk_g);
                #1;
            end
        end
        wait_done();
        finish_run();
    end

endmodule
